// File: rtl/acf_axi_regfile.sv
// AXI4-Lite register file: NUM_REGS registers of DW bits, RW or read-only per RO_MASK.
// Independent AW/W capture, write commit once both are present, two-state read FSM.

module acf_reg_slot #(
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DW/8-1:0]   strb,
    input  logic [DW-1:0]     wdata,
    output logic [DW-1:0]     q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            for (int b = 0; b < DW/8; b++) begin
                if (we && strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end
endmodule

module acf_axi_regfile #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          NUM_REGS           = 8,
    parameter int          C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [63:0] RO_MASK            = 64'h0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]                    wr_pulse
);
    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int SW    = DW / 8;
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int OFF_W = $clog2(SW);
    localparam logic [NUM_REGS-1:0] RO   = RO_MASK[NUM_REGS-1:0];
    localparam logic [IDX_W:0]      NREG = (IDX_W+1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [IDX_W-1:0] addr_idx(input logic [AW-1:0] a);
        return a[IDX_W+OFF_W-1 -: IDX_W];
    endfunction

    // Any address bit above the index field, or an index past NUM_REGS, is out of range.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        logic [AW-1:0] hi;
        hi = a >> (IDX_W + OFF_W);
        return (hi == '0) && ({1'b0, addr_idx(a)} < NREG);
    endfunction

    logic                 ready_en;
    logic                 aw_held, w_held;
    logic [AW-1:0]        aw_addr_q;
    logic [DW-1:0]        w_data_q;
    logic [SW-1:0]        w_strb_q;
    logic                 aw_hs, w_hs, commit;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [SW-1:0]        wr_strb;
    logic [IDX_W-1:0]     wr_idx;
    logic                 wr_ok;
    logic [NUM_REGS-1:0]  we;
    logic [NUM_REGS-1:0][DW-1:0] rd_vals;

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, status_in};

    assign S_AXI_AWREADY = ready_en & ~aw_held & ~S_AXI_BVALID;
    assign S_AXI_WREADY  = ready_en & ~w_held  & ~S_AXI_BVALID;
    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
    // A beat handshaking this edge counts as present, so commit can coincide with it.
    assign commit = (aw_held | aw_hs) & (w_held | w_hs);

    assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
    assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
    assign wr_idx  = addr_idx(wr_addr);
    assign wr_ok   = addr_ok(wr_addr) && !RO[wr_idx];

    always_comb begin
        we = '0;
        if (commit && wr_ok) we[wr_idx] = 1'b1;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ready_en     <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= '0;
            wr_pulse     <= '0;
        end else begin
            ready_en <= 1'b1;
            wr_pulse <= we;
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
                if (S_AXI_BVALID && S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (RO[k]) begin : g_ro
            assign reg_out[k*DW +: DW] = '0;
            assign rd_vals[k]          = status_in[k*DW +: DW];
        end else begin : g_rw
            logic [DW-1:0] q;
            acf_reg_slot #(.DW(DW)) u_slot (
                .clk   (S_AXI_ACLK),
                .rst_n (S_AXI_ARESETN),
                .we    (we[k]),
                .strb  (wr_strb),
                .wdata (wr_data),
                .q     (q)
            );
            assign reg_out[k*DW +: DW] = q;
            assign rd_vals[k]          = q;
        end
    end

    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;
    rd_state_t rd_state, rd_next;
    logic      ar_hs;

    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rd_state <= RD_IDLE;
        else                rd_state <= rd_next;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs) rd_next = RD_DATA;
            RD_DATA: if (S_AXI_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (rd_state)
            RD_IDLE: S_AXI_ARREADY = ready_en;
            RD_DATA: S_AXI_RVALID  = 1'b1;
            default: ;
        endcase
    end

    // Sampled at the AR handshake, so a same-edge write commit is not visible here.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= '0;
        end else if (ar_hs) begin
            if (addr_ok(S_AXI_ARADDR)) begin
                S_AXI_RDATA <= rd_vals[addr_idx(S_AXI_ARADDR)];
                S_AXI_RRESP <= RESP_OKAY;
            end else begin
                S_AXI_RDATA <= '0;
                S_AXI_RRESP <= RESP_SLVERR;
            end
        end
    end
endmodule

// File: tb/tb_acf_axi_regfile.sv
// Bench for acf_axi_regfile (DW=32, 8 regs, reg 7 read-only): directed cases then
// randomized traffic checked against an array-based register model.

module tb_acf_axi_regfile;
    localparam int          DW  = 32;
    localparam int          NR  = 8;
    localparam int          AW  = 5;
    localparam logic [63:0] ROM = 64'h80;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [AW-1:0]     S_AXI_AWADDR = '0;
    logic [2:0]        S_AXI_AWPROT = '0;
    logic              S_AXI_AWVALID = 1'b0;
    logic              S_AXI_AWREADY;
    logic [DW-1:0]     S_AXI_WDATA = '0;
    logic [DW/8-1:0]   S_AXI_WSTRB = '0;
    logic              S_AXI_WVALID = 1'b0;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY = 1'b0;
    logic [AW-1:0]     S_AXI_ARADDR = '0;
    logic [2:0]        S_AXI_ARPROT = '0;
    logic              S_AXI_ARVALID = 1'b0;
    logic              S_AXI_ARREADY;
    logic [DW-1:0]     S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY = 1'b0;
    logic [NR*DW-1:0]  reg_out;
    logic [NR*DW-1:0]  status_in = '0;
    logic [NR-1:0]     wr_pulse;

    logic [31:0] model [NR];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    acf_axi_regfile #(
        .C_S_AXI_DATA_WIDTH (DW),
        .NUM_REGS           (NR),
        .C_S_AXI_ADDR_WIDTH (AW),
        .RO_MASK            (ROM)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .status_in     (status_in),
        .wr_pulse      (wr_pulse)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [255:0] exp_reg_out();
        logic [255:0] r;
        for (int k = 0; k < NR; k++) r[k*32 +: 32] = ROM[k] ? 32'h0 : model[k];
        return r;
    endfunction

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int awd, input int wd,
                             output logic [1:0] r, output logic [7:0] p);
        bit awdn, wdn, awh, wh;
        int cyc;
        awdn = 0; wdn = 0; cyc = 0;
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        while (!(awdn && wdn) && cyc < 40) begin
            if (!awdn && cyc >= awd) S_AXI_AWVALID = 1'b1;
            if (!wdn && cyc >= wd)   S_AXI_WVALID  = 1'b1;
            awh = S_AXI_AWVALID && S_AXI_AWREADY;
            wh  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge clk); #1; cyc++;
            if (awh) begin awdn = 1; S_AXI_AWVALID = 1'b0; end
            if (wh)  begin wdn = 1;  S_AXI_WVALID  = 1'b0; end
            if (!(awdn && wdn)) begin
                chk("bvalid_early", S_AXI_BVALID, 0);
                if (awdn) chk("awready_held", S_AXI_AWREADY, 0);
                if (wdn)  chk("wready_held", S_AXI_WREADY, 0);
            end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk("aw_w_handshake", {awdn, wdn}, 2'b11);
        chk("bvalid_after_commit", S_AXI_BVALID, 1);
        r = S_AXI_BRESP;
        p = wr_pulse;
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
        chk("bvalid_clear", S_AXI_BVALID, 0);
        chk("wr_pulse_clear", wr_pulse, 0);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] r);
        bit hs;
        int n;
        hs = 0; n = 0;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
        while (!hs && n < 20) begin
            hs = S_AXI_ARREADY;
            @(posedge clk); #1; n++;
        end
        S_AXI_ARVALID = 1'b0;
        chk("ar_handshake", hs, 1);
        chk("rvalid", S_AXI_RVALID, 1);
        d = S_AXI_RDATA;
        r = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
        chk("rvalid_clear", S_AXI_RVALID, 0);
    endtask

    task automatic wr_chk(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int awd, input int wd);
        int k;
        logic [1:0] r;
        logic [7:0] p;
        k = int'(a[4:2]);
        axi_write(a, d, s, awd, wd, r, p);
        chk("bresp", r, ROM[k] ? 2'b10 : 2'b00);
        chk("wr_pulse", p, ROM[k] ? 8'h0 : (8'h1 << k));
        if (!ROM[k]) model[k] = merge(model[k], d, s);
    endtask

    task automatic rd_chk(input logic [4:0] a);
        int k;
        logic [31:0] d;
        logic [1:0] r;
        k = int'(a[4:2]);
        axi_read(a, d, r);
        chk("rdata", d, ROM[k] ? status_in[k*32 +: 32] : model[k]);
        chk("rresp", r, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        bit hs;
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        status_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        chk("rst_resps", {S_AXI_BRESP, S_AXI_RRESP}, 4'h0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_reg_out", reg_out, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_first_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        @(posedge clk); #1;
        chk("ready_after_first_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        // Basic writes and readback
        for (int i = 0; i < 4; i++) wr_chk(5'(i*4), 32'(i+1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(i*4), d, r);
            chk("basic_rdata", d, 32'(i+1));
            chk("basic_rresp", r, 2'b00);
        end

        // Byte-strobe merge
        wr_chk(5'h04, 32'hAABBCCDD, 4'hF, 0, 0);
        wr_chk(5'h04, 32'h11223344, 4'b0101, 0, 0);
        axi_read(5'h04, d, r);
        chk("strb_merge", d, 32'hAA22CC44);

        // W three cycles ahead of AW
        wr_chk(5'h10, 32'h5555AAAA, 4'hF, 3, 0);
        rd_chk(5'h10);

        // Read-only register: write rejected, status returned
        status_in[7*32 +: 32] = 32'hDEADBEEF;
        wr_chk(5'h1C, 32'h1, 4'hF, 0, 0);
        axi_read(5'h1C, d, r);
        chk("ro_rdata", d, 32'hDEADBEEF);
        chk("ro_rresp", r, 2'b00);
        chk("reg_out_after_ro", reg_out, exp_reg_out());

        // BREADY held low while a read completes
        S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'hCAFEF00D; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        model[0] = 32'hCAFEF00D;
        chk("hold_bvalid_start", S_AXI_BVALID, 1);
        rd_chk(5'h00);
        for (int i = 0; i < 10; i++) begin
            chk("hold_bvalid", S_AXI_BVALID, 1);
            chk("hold_bresp", S_AXI_BRESP, 2'b00);
            chk("hold_readies", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
            @(posedge clk); #1;
        end
        S_AXI_BREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_BREADY = 1'b0;
        chk("hold_bvalid_clear", S_AXI_BVALID, 0);

        // Randomized traffic against the model
        for (int n = 0; n < 80; n++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                wr_chk(a, $urandom, 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                status_in[7*32 +: 32] = $urandom;
                rd_chk(a);
            end
            if (n % 10 == 9) chk("rand_reg_out", reg_out, exp_reg_out());
        end

        // Reset between AW and W
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        @(posedge clk); #1;
        S_AXI_AWVALID = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
        chk("midrst_valids", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 6'h0);
        chk("midrst_rdata", S_AXI_RDATA, 0);
        chk("midrst_reg_out", reg_out, 0);
        chk("midrst_wr_pulse", wr_pulse, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
        @(posedge clk); #1;
        S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        hs = 0;
        for (int n = 0; n < 20 && !hs; n++) begin
            hs = S_AXI_WREADY;
            @(posedge clk); #1;
        end
        S_AXI_WVALID = 1'b0;
        chk("midrst_w_accept", hs, 1);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_bvalid", S_AXI_BVALID, 0);
            chk("midrst_no_pulse", wr_pulse, 0);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 7; k++) rd_chk(5'(k*4));
        chk("midrst_reg_out_final", reg_out, exp_reg_out());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
